// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// The multiplier lives in the low half of the accumulator and shifts out as it is consumed.
module seq_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     partial;

  always_comb begin
    partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d   = {partial, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(WIDTH);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // NOTE: datapath registers carry no reset; every multiply overwrites them on load.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      mcand_q <= a_i;
      acc_q   <= {{WIDTH{1'b0}}, b_i};
    end else if (run_i) begin
      acc_q   <= acc_d;
    end
  end

  // The final product is taken from the step being computed, not the stored value.
  assign last_o    = run_i && (cnt_q == CW'(1));
  assign product_o = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Registered integer ALU with start/done handshake; single-cycle logic/add/sub/slt.
// Define SEQ_ALU_MUL_EN to build the multi-cycle unsigned multiply (opcode 1000).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  logic             is_sub, add_ovf, is_mul;
  logic [WIDTH-1:0] b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic             alu_cout, alu_ovf;

  always_comb begin
    is_sub  = (ctrl_i == OP_SUB) || (ctrl_i == OP_SLT);
    b_eff   = is_sub ? ~src2_i : src2_i;
    sum     = {1'b0, src1_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf = (src1_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (ctrl_i)
      OP_AND:  alu_res = src1_i & src2_i;
      OP_OR:   alu_res = src1_i | src2_i;
      OP_NOR:  alu_res = ~(src1_i | src2_i);
      OP_NAND: alu_res = ~(src1_i & src2_i);
      OP_ADD, OP_SUB: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = add_ovf;
      end
      // Sign of the true difference is N^V, correct even when A-B overflows.
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;

  assign is_mul = (ctrl_i == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start_i && is_mul && (state_q != ST_RUN)),
    .run_i     (state_q == ST_RUN),
    .a_i       (src1_i),
    .b_i       (src2_i),
    .last_o    (mul_last),
    .product_o (mul_product)
  );
`else
  assign is_mul = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
`ifdef SEQ_ALU_MUL_EN
    result_hi_d = result_hi_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i && is_mul) begin
          state_d = ST_RUN;
        end else if (start_i) begin
          state_d  = ST_DONE;
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          cout_d   = alu_cout;
          ovf_d    = alu_ovf;
`ifdef SEQ_ALU_MUL_EN
          result_hi_d = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      ST_RUN: begin
        if (mul_last) begin
          state_d     = ST_DONE;
          result_d    = mul_product[WIDTH-1:0];
          result_hi_d = mul_product[2*WIDTH-1:WIDTH];
          zero_d      = (mul_product[WIDTH-1:0] == '0);
          cout_d      = 1'b0;
          ovf_d       = 1'b0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, active-low.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      result_hi_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
`ifdef SEQ_ALU_MUL_EN
      result_hi_q <= result_hi_d;
`endif
    end
  end

  assign done_o     = (state_q == ST_DONE);
  assign result_o   = result_q;
  assign zero_o     = zero_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
`ifdef SEQ_ALU_MUL_EN
  assign busy_o      = (state_q == ST_RUN);
  assign result_hi_o = result_hi_q;
`else
  assign busy_o      = 1'b0;
  assign result_hi_o = '0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH = 32); MUL scenarios follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'b0000;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy, done, zero, cout, ovf;
  logic [31:0] res, res_hi;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .ctrl_i      (ctrl),
    .src1_i      (src1),
    .src2_i      (src2),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (res),
    .result_hi_o (res_hi),
    .zero_o      (zero),
    .cout_o      (cout),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Present one request for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; ctrl = op; src1 = a; src2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_res: got %h want 0", res); end
    checks++; if (res_hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", res_hi); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {cout, ovf}); end
    rst = 1'b1;
  endtask

  task automatic test_add();
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done: got %b want 1", done); end
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL add_res: got %h want 80000000", res); end
    checks++; if ({ovf, cout, zero} !== 3'b100) begin errors++; $display("FAIL add_flags(ovf,cout,zero): got %b want 100", {ovf, cout, zero}); end
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL add_wrap_res: got %h want 0", res); end
    checks++; if ({ovf, cout, zero} !== 3'b011) begin errors++; $display("FAIL add_wrap_flags: got %b want 011", {ovf, cout, zero}); end
  endtask

  task automatic test_sub_slt();
    issue(4'b0110, 32'd5, 32'd5);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL sub_res: got %h want 0", res); end
    checks++; if ({ovf, cout, zero} !== 3'b011) begin errors++; $display("FAIL sub_flags: got %b want 011", {ovf, cout, zero}); end
    issue(4'b0110, 32'd3, 32'd5);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_borrow_res: got %h want fffffffe", res); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout: got %b want 0", cout); end
    issue(4'b0111, 32'h8000_0000, 32'h0000_0001);
    checks++; if (res !== 32'h1) begin errors++; $display("FAIL slt_ovf_res: got %h want 1", res); end
    checks++; if ({ovf, cout} !== 2'b00) begin errors++; $display("FAIL slt_flags: got %b want 00", {ovf, cout}); end
    issue(4'b0111, 32'h0000_0002, 32'hFFFF_FFFF);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL slt_pos_neg: got %h want 0", res); end
  endtask

  task automatic test_logic();
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (res !== 32'h0000_F000) begin errors++; $display("FAIL and_res: got %h want 0000f000", res); end
    issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (res !== 32'h0000_FFF0) begin errors++; $display("FAIL or_res: got %h want 0000fff0", res); end
    issue(4'b1100, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (res !== 32'hFFFF_000F) begin errors++; $display("FAIL nor_res: got %h want ffff000f", res); end
    issue(4'b1101, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (res !== 32'hFFFF_0FFF) begin errors++; $display("FAIL nand_res: got %h want ffff0fff", res); end
  endtask

  task automatic test_illegal();
    issue(4'b0011, 32'h1234_5678, 32'h1111_1111);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL illegal_done: got %b want 1", done); end
    checks++; if ({res, res_hi} !== 64'h0) begin errors++; $display("FAIL illegal_res: got %h want 0", {res, res_hi}); end
    checks++; if ({zero, cout, ovf} !== 3'b100) begin errors++; $display("FAIL illegal_flags: got %b want 100", {zero, cout, ovf}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd2;
    @(negedge clk);
    checks++; if ({done, res} !== {1'b1, 32'd3}) begin errors++; $display("FAIL b2b_first: got %b/%h want 1/3", done, res); end
    src1 = 32'd10; src2 = 32'd20;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({done, res} !== {1'b1, 32'd30}) begin errors++; $display("FAIL b2b_second: got %b/%h want 1/1e", done, res); end
    @(negedge clk);
    checks++; if ({done, res} !== {1'b0, 32'd30}) begin errors++; $display("FAIL b2b_idle_hold: got %b/%h want 0/1e", done, res); end
  endtask

`ifdef SEQ_ALU_MUL_EN
  task automatic test_mul();
    int busy_cnt = 0;
    int cyc = 0;
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    while (busy === 1'b1 && cyc < 40) begin
      if (done !== 1'b0 || res !== 32'd30) begin
        errors++; $display("FAIL mul_during_run: got done=%b res=%h want 0/1e", done, res);
      end
      start = (cyc == 5);
      ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd1;
      busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 32", busy_cnt); end
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL mul_done: got %b want 10", {done, busy}); end
    checks++; if ({res_hi, res} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL mul_max: got %h want fffffffe00000001", {res_hi, res}); end
    checks++; if ({zero, cout, ovf} !== 3'b000) begin errors++; $display("FAIL mul_flags: got %b want 000", {zero, cout, ovf}); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL mul_ignored_start: got %b want 00", {done, busy}); end
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
    repeat (32) @(negedge clk);
    checks++; if ({done, res_hi, res, zero} !== {1'b1, 64'h0000_0001_0000_0000, 1'b1}) begin
      errors++; $display("FAIL mul_2p32: got %b %h %b want 1 0000000100000000 1", done, {res_hi, res}, zero);
    end
  endtask

  task automatic test_abort();
    issue(4'b1000, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_state: got %b want 00", {busy, done}); end
    checks++; if ({res_hi, res, zero, cout, ovf} !== {64'h0, 3'b100}) begin
      errors++; $display("FAIL abort_outputs: got %h %b want 0 100", {res_hi, res}, {zero, cout, ovf});
    end
    repeat (30) @(negedge clk);
    checks++; if ({busy, done, res} !== {2'b00, 32'h0}) begin errors++; $display("FAIL abort_discard: got %b %h want 00 0", {busy, done}, res); end
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if ({done, res} !== {1'b1, 32'h0000_F000}) begin errors++; $display("FAIL abort_and: got %b %h want 1 0000f000", done, res); end
  endtask
`else
  task automatic test_mul();
    issue(4'b1000, 32'd7, 32'd9);
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL nomul_done: got %b want 10", {done, busy}); end
    checks++; if ({res_hi, res, zero} !== {64'h0, 1'b1}) begin errors++; $display("FAIL nomul_res: got %h %b want 0 1", {res_hi, res}, zero); end
  endtask

  task automatic test_abort();
    issue(4'b0010, 32'd7, 32'd9);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if ({busy, done, res, zero} !== {2'b00, 32'h0, 1'b1}) begin
      errors++; $display("FAIL abort_outputs: got %b %h %b want 00 0 1", {busy, done}, res, zero);
    end
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if ({done, res} !== {1'b1, 32'h0000_F000}) begin errors++; $display("FAIL abort_and: got %b %h want 1 0000f000", done, res); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_illegal();
    test_back_to_back();
    test_mul();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered integer ALU with a start/done handshake that replaces the single-bit ripple slice chain in the datapath. It performs the logic, add/subtract and set-less-than operations in one cycle and an unsigned shift-add multiply over WIDTH cycles. Flags are computed at full width with overflow-correct SLT. It sits between the register file read ports and the write-back mux, and the control unit sequences it.

## Interface
- WIDTH, 32, operand/result width in bits; legal values are ≥ 2.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-low reset.
- start_i  input  1  operation request; accepted only when busy_o = 0.
- ctrl_i  input  4  opcode, sampled on accept.
- src1_i  input  WIDTH  operand A, sampled on accept.
- src2_i  input  WIDTH  operand B, sampled on accept.
- busy_o  output  1  multiply in progress.
- done_o  output  1  one-cycle pulse; all result outputs are valid and held until the next done_o.
- result_o  output  WIDTH  result, or product low word.
- result_hi_o  output  WIDTH  product high word; 0 for non-MUL operations.
- zero_o  output  1  result_o == 0.
- cout_o  output  1  carry out of the MSB for ADD/SUB (SUB: 1 = no borrow); 0 otherwise.
- overflow_o  output  1  signed overflow for ADD/SUB; 0 otherwise.

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB, computed as A + ~B + 1
  - 0111 SLT, signed; result = {0…, N^V} from A−B
  - 1100 NOR
  - 1101 NAND
  - 1000 MUL
  - Any other code: all result outputs 0, done_o still pulses.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start_i and a non-MUL op: register the result and flags, go to DONE.
- IDLE/DONE with start_i and MUL:
  - Load multiplicand, multiplier and a 2·WIDTH accumulator of 0.
  - Load counter = WIDTH.
  - Go to RUN.
- IDLE/DONE without start_i: go to (or stay in) IDLE.
- DONE: done_o = 1.
- RUN, each cycle:
  - If the multiplier LSB = 1, add the multiplicand into the accumulator's upper half, keeping the carry.
  - Shift the accumulator right by 1 and the multiplier right by 1.
  - Decrement the counter.
  - When the counter reaches 1 (last iteration), go to DONE with {result_hi_o, result_o} = product.
- start_i while busy_o = 1 is ignored; no queueing.
- Result outputs change only on the transition into DONE.
- Reset (rst_i = 0 at an edge), including mid-RUN:
  - State IDLE.
  - busy_o, done_o, result_o, result_hi_o, cout_o and overflow_o all 0.
  - zero_o = 1, consistent with result_o = 0.
  - The multiply in progress is discarded.
- All arithmetic is modulo 2^WIDTH. The multiply is unsigned WIDTH × WIDTH → 2·WIDTH with no truncation.

## Timing
- Single-cycle ops:
  - start_i is sampled at edge k; done_o and the results are valid after edge k+1.
  - Back-to-back starts give 1 result per cycle.
- MUL:
  - Accept at edge k; busy_o is high after edges k+1 … k+WIDTH.
  - done_o is high after edge k+WIDTH+1, with busy_o low in that same cycle.
- A start_i in the DONE cycle is accepted; done_o then falls or re-pulses per the rules above.

## Configuration
- SEQ_ALU_MUL_EN defined:
  - MUL is implemented as described.
  - The RUN state and the multiplier datapath exist.
- SEQ_ALU_MUL_EN undefined:
  - 1000 is treated as an illegal opcode: single cycle, all outputs 0, done_o pulses.
  - busy_o is tied to 0 and result_hi_o to 0.
  - No RUN state.

## Structure
- Package seq_alu_pkg:
  - Opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND, OP_MUL).
  - State encoding (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module, seq_alu_mul:
  - Holds the iterative shift-add datapath and its counter.
  - Parameterised by WIDTH.
  - Instantiated only under SEQ_ALU_MUL_EN.
- Top level holds:
  - The FSM.
  - The combinational logic/add-sub unit.
  - The output registers.

## Test plan
- Reset: hold rst_i = 0 for 2 cycles → all outputs 0 except zero_o = 1; busy_o = 0.
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow_o = 1, cout_o = 0, done_o one cycle after start.
- SUB 5 − 5 → result 0, zero_o = 1, cout_o = 1.
- SLT with A = 0x80000000, B = 0x00000001 → result 1, even though A−B overflows.
- MUL 0xFFFFFFFF × 0xFFFFFFFF:
  - Expect result_hi_o = 0xFFFFFFFE and result_o = 0x00000001.
  - busy_o high for 32 cycles; done_o 33 cycles after start.
  - A second start_i during busy_o is ignored.
- Abort: start MUL 7 × 9, drop rst_i at RUN cycle 10.
  - Expect IDLE with all outputs at their reset values.
  - A following AND 0xF0F0 & 0xFF00 gives 0xF000.
